// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write ports, packed read ports, clear sweep and debug read.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     WRITE0;
    logic [ADDR_W-1:0]        INADDRESS0;
    logic [DATA_W-1:0]        IN0;
    logic                     WRITE1;
    logic [ADDR_W-1:0]        INADDRESS1;
    logic [DATA_W-1:0]        IN1;
    logic [NUM_RD*ADDR_W-1:0] OUTADDRESS;
    logic [NUM_RD*DATA_W-1:0] OUT;
    logic                     CLEAR;
    logic                     BUSY;
    logic [7:0]               DROP_CNT;
    logic [ADDR_W-1:0]        DEBUG_ADDR;
    logic [DATA_W-1:0]        DEBUG_DATA;

    modport master (
        output WRITE0, INADDRESS0, IN0, WRITE1, INADDRESS1, IN1,
               OUTADDRESS, CLEAR, DEBUG_ADDR,
        input  OUT, BUSY, DROP_CNT, DEBUG_DATA
    );

    modport slave (
        input  WRITE0, INADDRESS0, IN0, WRITE1, INADDRESS1, IN1,
               OUTADDRESS, CLEAR, DEBUG_ADDR,
        output OUT, BUSY, DROP_CNT, DEBUG_DATA
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with async reads, two prioritised write ports, clear sweep and drop counter.
// Optional write-to-read bypass enabled by defining REG_FILE_BYPASS_EN.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              busy_q;
    logic [7:0]        drop_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              zero0, zero1;
    logic              wr0_act, wr1_act;
    logic              drop0, drop1;
    logic [8:0]        cnt_sum;

    logic [ADDR_W-1:0] rd_addr [NUM_RD+1];
    logic [DATA_W-1:0] rd_data [NUM_RD+1];

    always_comb begin
        zero0   = (ZERO_REG != 0) && (bus.INADDRESS0 == '0);
        zero1   = (ZERO_REG != 0) && (bus.INADDRESS1 == '0);
        wr0_act = bus.WRITE0 && !zero0 && (state == IDLE);
        wr1_act = bus.WRITE1 && !zero1 && (state == IDLE);
        drop0   = bus.WRITE0 && !zero0 && (state == SWEEP);
        drop1   = bus.WRITE1 && !zero1 && (state == SWEEP);
        cnt_sum = {1'b0, drop_cnt} + 9'(drop0) + 9'(drop1);
    end

    // Slot NUM_RD carries the debug port so it shares the read/bypass path.
    always_comb begin
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_addr[k] = bus.OUTADDRESS[k*ADDR_W +: ADDR_W];
        end
        rd_addr[NUM_RD] = bus.DEBUG_ADDR;
    end

    always_comb begin
        for (int unsigned k = 0; k <= NUM_RD; k++) begin
            rd_data[k] = mem[rd_addr[k]];
`ifdef REG_FILE_BYPASS_EN
            if (wr1_act && (bus.INADDRESS1 == rd_addr[k])) begin
                rd_data[k] = bus.IN1;
            end else if (wr0_act && (bus.INADDRESS0 == rd_addr[k])) begin
                rd_data[k] = bus.IN0;
            end
`endif
            if ((ZERO_REG != 0) && (rd_addr[k] == '0)) begin
                rd_data[k] = '0;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            bus.OUT[k*DATA_W +: DATA_W] = rd_data[k];
        end
        bus.DEBUG_DATA = rd_data[NUM_RD];
    end

    assign bus.BUSY     = busy_q;
    assign bus.DROP_CNT = drop_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state    <= IDLE;
            ptr      <= '0;
            busy_q   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Port 1 is assigned last so it wins on an address collision.
                    if (wr0_act) mem[bus.INADDRESS0] <= bus.IN0;
                    if (wr1_act) mem[bus.INADDRESS1] <= bus.IN1;
                    if (bus.CLEAR) begin
                        state  <= SWEEP;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SWEEP: begin
                    mem[ptr] <= '0;
                    if (ptr == '1) begin
                        state  <= IDLE;
                        ptr    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    ptr    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
            drop_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed vector table, sweep/drop/reset sequences and random traffic.
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus();

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents, sweep position (-1 when idle), drop total.
    logic [31:0] m_mem [DEPTH];
    int          m_pos   = -1;
    int          m_drops = 0;

    typedef struct {
        logic        w0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        w1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
        if (m_pos < 0 && bus.WRITE1 && bus.INADDRESS1 == a) return bus.IN1;
        if (m_pos < 0 && bus.WRITE0 && bus.INADDRESS0 == a) return bus.IN0;
`endif
        return m_mem[a];
    endfunction

    task automatic model_step();
        int n;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
            m_pos   = -1;
            m_drops = 0;
        end else if (m_pos < 0) begin
            if (bus.WRITE0 && bus.INADDRESS0 != 5'd0) m_mem[bus.INADDRESS0] = bus.IN0;
            if (bus.WRITE1 && bus.INADDRESS1 != 5'd0) m_mem[bus.INADDRESS1] = bus.IN1;
            if (bus.CLEAR) m_pos = 0;
        end else begin
            n = 0;
            if (bus.WRITE0 && bus.INADDRESS0 != 5'd0) n++;
            if (bus.WRITE1 && bus.INADDRESS1 != 5'd0) n++;
            m_drops = (m_drops + n > 255) ? 255 : m_drops + n;
            m_mem[m_pos] = 32'd0;
            m_pos++;
            if (m_pos == DEPTH) m_pos = -1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.WRITE0 = 1'b0;
        bus.WRITE1 = 1'b0;
        bus.CLEAR  = 1'b0;
    endtask

    task automatic check_all(input string tag, input bit with_reads);
        if (with_reads) begin
            check({tag, "_out0"}, bus.OUT[31:0],  exp_read(bus.OUTADDRESS[4:0]));
            check({tag, "_out1"}, bus.OUT[63:32], exp_read(bus.OUTADDRESS[9:5]));
            check({tag, "_dbg"},  bus.DEBUG_DATA, exp_read(bus.DEBUG_ADDR));
        end
        check({tag, "_busy"}, 32'(bus.BUSY), 32'(m_pos >= 0));
        check({tag, "_drop"}, 32'(bus.DROP_CNT), 32'(m_drops));
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            bus.DEBUG_ADDR = 5'(a);
            bus.OUTADDRESS = {5'(a), 5'(a)};
            #1;
            check({tag, "_dbg"},  bus.DEBUG_DATA, 32'd0);
            check({tag, "_out1"}, bus.OUT[63:32], 32'd0);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.BUSY && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(bus.BUSY), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        idle_inputs();
        bus.INADDRESS0 = '0; bus.IN0 = '0;
        bus.INADDRESS1 = '0; bus.IN1 = '0;
        bus.OUTADDRESS = '0; bus.DEBUG_ADDR = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset after random writes, with a write still pending in the reset cycle
        for (int i = 0; i < 8; i++) begin
            bus.WRITE0 = 1'b1; bus.INADDRESS0 = 5'($urandom_range(1, 31)); bus.IN0 = $urandom;
            bus.WRITE1 = 1'b1; bus.INADDRESS1 = 5'($urandom_range(1, 31)); bus.IN1 = $urandom;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        check_all_zero("rst");
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_drop", 32'(bus.DROP_CNT), 32'd0);

        // Directed vector table
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'h12345678, 5'd5,  5'd0,  32'h12345678, 32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'h12345678};
        vecs[2] = '{1'b1, 5'd3,  32'h00000011, 1'b1, 5'd4,  32'h00000022, 5'd3,  5'd4,  32'h00000011, 32'h00000022};
        vecs[3] = '{1'b1, 5'd1,  32'h0000BBBB, 1'b1, 5'd0,  32'h0000AAAA, 5'd0,  5'd1,  32'h0,        32'h0000BBBB};
        vecs[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd30, 32'h0BADF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0BADF00D};
        vecs[5] = '{1'b1, 5'd4,  32'h0,        1'b0, 5'd3,  32'h99999999, 5'd4,  5'd3,  32'h0,        32'h00000011};
        for (int v = 0; v < 6; v++) begin
            bus.WRITE0 = vecs[v].w0; bus.INADDRESS0 = vecs[v].a0; bus.IN0 = vecs[v].d0;
            bus.WRITE1 = vecs[v].w1; bus.INADDRESS1 = vecs[v].a1; bus.IN1 = vecs[v].d1;
            tick();
            idle_inputs();
            bus.OUTADDRESS = {vecs[v].r1, vecs[v].r0};
            bus.DEBUG_ADDR = vecs[v].r0;
            #1;
            check($sformatf("vec%0d_out0", v), bus.OUT[31:0],  vecs[v].e0);
            check($sformatf("vec%0d_out1", v), bus.OUT[63:32], vecs[v].e1);
            check($sformatf("vec%0d_dbg", v),  bus.DEBUG_DATA, vecs[v].e0);
        end

        // Fill with index+1, then sweep and measure BUSY length
        for (int i = 0; i < DEPTH; i++) begin
            bus.WRITE0 = 1'b1; bus.INADDRESS0 = 5'(i); bus.IN0 = 32'(i + 1);
            tick();
        end
        idle_inputs();
        bus.CLEAR = 1'b1;
        tick();
        bus.CLEAR = 1'b0;
        bus.OUTADDRESS = {5'd10, 5'd9};
        bus.DEBUG_ADDR = 5'd31;
        #1;
        check("sweep_busy_start", 32'(bus.BUSY), 32'd1);
        cnt = 0;
        while (bus.BUSY && cnt < 100) begin
            if (cnt == 10) begin
                check("sweep_e9",  bus.OUT[31:0],  32'd0);
                check("sweep_e10", bus.OUT[63:32], 32'd11);
            end
            check_all("sweep", 1'b1);
            tick();
            cnt++;
        end
        check("sweep_len", 32'(cnt), 32'd32);
        check_all_zero("post_sweep");

        // Dropped writes late in a sweep
        bus.CLEAR = 1'b1;
        bus.WRITE0 = 1'b1; bus.INADDRESS0 = 5'd3; bus.IN0 = 32'h00000333;
        bus.WRITE1 = 1'b1; bus.INADDRESS1 = 5'd7; bus.IN1 = 32'h00000777;
        tick();
        idle_inputs();
        for (int i = 0; i < 20; i++) tick();
        bus.WRITE0 = 1'b1; bus.INADDRESS0 = 5'd3; bus.IN0 = 32'h3333AAAA;
        bus.WRITE1 = 1'b1; bus.INADDRESS1 = 5'd7; bus.IN1 = 32'h7777BBBB;
        for (int i = 0; i < 3; i++) tick();
        idle_inputs();
        wait_idle("drop");
        bus.OUTADDRESS = {5'd7, 5'd3};
        #1;
        check("drop_cnt6", 32'(bus.DROP_CNT), 32'd6);
        check("drop_e3", bus.OUT[31:0],  32'd0);
        check("drop_e7", bus.OUT[63:32], 32'd0);

        // Saturation across repeated sweeps
        bus.WRITE0 = 1'b1; bus.INADDRESS0 = 5'd3;
        bus.WRITE1 = 1'b1; bus.INADDRESS1 = 5'd7;
        bus.CLEAR  = 1'b1;
        for (int i = 0; i < 250; i++) begin
            bus.IN0 = $urandom; bus.IN1 = $urandom;
            tick();
        end
        idle_inputs();
        wait_idle("sat");
        check("drop_sat", 32'(bus.DROP_CNT), 32'd255);
        check_all("sat", 1'b1);

        // Reset in the middle of a sweep
        for (int i = 20; i < 26; i++) begin
            bus.WRITE0 = 1'b1; bus.INADDRESS0 = 5'(i); bus.IN0 = 32'hF0000000 | 32'(i);
            tick();
        end
        idle_inputs();
        bus.CLEAR = 1'b1;
        tick();
        bus.CLEAR = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(bus.BUSY), 32'd0);
        check("midrst_drop", 32'(bus.DROP_CNT), 32'd0);
        check_all_zero("midrst");

        // CLEAR during a sweep must not extend it
        bus.CLEAR = 1'b1;
        tick();
        bus.CLEAR = 1'b0;
        cnt = 0;
        while (bus.BUSY && cnt < 100) begin
            bus.CLEAR = (cnt >= 5 && cnt <= 8);
            tick();
            cnt++;
        end
        bus.CLEAR = 1'b0;
        check("reclear_len", 32'(cnt), 32'd32);

        // Same-cycle read of a write in progress
        bus.WRITE0 = 1'b1; bus.INADDRESS0 = 5'd9; bus.IN0 = 32'h11111111;
        tick();
        bus.WRITE0 = 1'b1; bus.INADDRESS0 = 5'd9; bus.IN0 = 32'hA5A5A5A5;
        bus.OUTADDRESS = {5'd9, 5'd0};
        bus.DEBUG_ADDR = 5'd9;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("byp_same", bus.OUT[63:32], 32'hA5A5A5A5);
        check("byp_dbg",  bus.DEBUG_DATA, 32'hA5A5A5A5);
`else
        check("byp_same", bus.OUT[63:32], 32'h11111111);
        check("byp_dbg",  bus.DEBUG_DATA, 32'h11111111);
`endif
        tick();
        idle_inputs();
        #1;
        check("byp_next", bus.OUT[63:32], 32'hA5A5A5A5);
        bus.WRITE0 = 1'b1; bus.INADDRESS0 = 5'd9; bus.IN0 = 32'h00000001;
        bus.WRITE1 = 1'b1; bus.INADDRESS1 = 5'd9; bus.IN1 = 32'h00000002;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("byp_prio", bus.OUT[63:32], 32'h00000002);
`else
        check("byp_prio", bus.OUT[63:32], 32'hA5A5A5A5);
`endif
        tick();
        idle_inputs();
        #1;
        check("byp_prio_next", bus.OUT[63:32], 32'h00000002);

        // Randomised traffic against the model
        for (int c = 0; c < 800; c++) begin
            rst        = ($urandom_range(0, 149) == 0);
            bus.CLEAR  = ($urandom_range(0, 29) == 0);
            bus.WRITE0 = 1'($urandom_range(0, 1));
            bus.WRITE1 = 1'($urandom_range(0, 1));
            bus.INADDRESS0 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            bus.INADDRESS1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            bus.IN0 = $urandom;
            bus.IN1 = $urandom;
            bus.OUTADDRESS = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
            bus.DEBUG_ADDR = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) bus.OUTADDRESS[4:0] = bus.INADDRESS0;
            if ($urandom_range(0, 2) == 0) bus.OUTADDRESS[9:5] = bus.INADDRESS1;
            #1;
            check_all("rand", !rst);
            tick();
        end
        rst = 1'b0;
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
